// File: rtl/ad7656_pkg.sv
// Shared types and constants for the AD7656 sample sequencing and averaging block.
// NUM_CH : number of converter channels per frame
// DATA_W : width of one channel sample
// CHAN_W : width of the output channel index
package ad7656_pkg;

    localparam int unsigned NUM_CH = 6;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned CHAN_W = 3;

    typedef enum logic [0:0] {
        StIdle,
        StWaitDone
    } state_e;

    typedef logic signed [DATA_W-1:0] sample_t;
    typedef sample_t [NUM_CH-1:0] frame_t;

endpackage

// File: rtl/ad7656_frame_buf.sv
// Single-frame output buffer with a valid/ready serialiser.
// Ports:
//   sys_clk_i, rst_n_i : clock, asynchronous active-low reset
//   load_i, frame_i    : load a complete averaged frame (accepted only while empty)
//   full_o             : buffer holds a frame that has not been fully sent
//   m_valid_o/m_ready_i: stream handshake
//   m_data_o/m_chan_o/m_last_o : current word, its channel index, last-word flag
module ad7656_frame_buf
    import ad7656_pkg::*;
(
    input  logic              sys_clk_i,
    input  logic              rst_n_i,
    input  logic              load_i,
    input  frame_t            frame_i,
    output logic              full_o,
    output logic              m_valid_o,
    input  logic              m_ready_i,
    output logic [DATA_W-1:0] m_data_o,
    output logic [CHAN_W-1:0] m_chan_o,
    output logic              m_last_o
);

    frame_t              frame_q, frame_d;
    logic                full_q, full_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [CHAN_W-1:0]   chan_q, chan_d;
    logic                last_q, last_d;
    logic [CHAN_W-1:0]   chan_nxt;

    always_comb begin
        frame_d  = frame_q;
        full_d   = full_q;
        data_d   = data_q;
        chan_d   = chan_q;
        last_d   = last_q;
        chan_nxt = chan_q + 1'b1;
        if (full_q) begin
            if (m_ready_i) begin
                if (last_q) begin
                    full_d = 1'b0;
                end else begin
                    // Pre-register the next word so data/chan/last are flop outputs.
                    chan_d = chan_nxt;
                    data_d = frame_q[chan_nxt];
                    last_d = (chan_nxt == CHAN_W'(NUM_CH - 1));
                end
            end
        end else if (load_i) begin
            frame_d = frame_i;
            full_d  = 1'b1;
            data_d  = frame_i[0];
            chan_d  = '0;
            last_d  = 1'b0;
        end
    end

    always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            frame_q <= '0;
            full_q  <= 1'b0;
            data_q  <= '0;
            chan_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            frame_q <= frame_d;
            full_q  <= full_d;
            data_q  <= data_d;
            chan_q  <= chan_d;
            last_q  <= last_d;
        end
    end

    assign full_o    = full_q;
    assign m_valid_o = full_q;
    assign m_data_o  = data_q;
    assign m_chan_o  = chan_q;
    assign m_last_o  = last_q;

endmodule

// File: rtl/ad7656_sample_ctrl.sv
// AD7656 conversion sequencer and frame averager.
// Issues a periodic one-cycle start_flag_o, waits (bounded) for convst_done_i, accumulates
// 2^AVG_LOG2 six-channel frames, and streams the averaged frame over valid/ready.
// Ports:
//   sys_clk_i, rst_n_i         : clock, asynchronous active-low reset
//   enable_i                   : run enable; low idles and clears the averaging state
//   start_flag_o               : conversion request pulse to the read driver
//   convst_done_i, chN_data_i  : frame-complete pulse and the six channel samples
//   m_valid_o .. m_last_o      : averaged-sample stream, chan 0..5, last on chan 5
//   overrun_o                  : sticky, an averaged frame was dropped (buffer full)
//   timeout_cnt_o              : saturating count of lost conversions
module ad7656_sample_ctrl
    import ad7656_pkg::*;
#(
    parameter int unsigned PERIOD_CYC  = 1000,
    parameter int unsigned AVG_LOG2    = 2,
    parameter int unsigned TIMEOUT_CYC = 600
) (
    input  logic              sys_clk_i,
    input  logic              rst_n_i,
    input  logic              enable_i,
    output logic              start_flag_o,
    input  logic              convst_done_i,
    input  logic [DATA_W-1:0] ch1_data_i,
    input  logic [DATA_W-1:0] ch2_data_i,
    input  logic [DATA_W-1:0] ch3_data_i,
    input  logic [DATA_W-1:0] ch4_data_i,
    input  logic [DATA_W-1:0] ch5_data_i,
    input  logic [DATA_W-1:0] ch6_data_i,
    output logic              m_valid_o,
    input  logic              m_ready_i,
    output logic [DATA_W-1:0] m_data_o,
    output logic [CHAN_W-1:0] m_chan_o,
    output logic              m_last_o,
    output logic              overrun_o,
    output logic [15:0]       timeout_cnt_o
);

    localparam int unsigned ACC_W  = DATA_W + AVG_LOG2;
    localparam int unsigned FCNT_W = AVG_LOG2 + 1;
    localparam logic [15:0] PERIOD_LAST  = 16'(PERIOD_CYC - 1);
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYC - 1);
    localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'((1 << AVG_LOG2) - 1);

    typedef logic signed [ACC_W-1:0] acc_t;

    state_e            state_q, state_d;
    logic [15:0]       period_q, period_d;
    logic [15:0]       to_cnt_q, to_cnt_d;
    logic [15:0]       tmo_cnt_q, tmo_cnt_d;
    logic              start_q, start_d;
    acc_t              acc_q [NUM_CH];
    acc_t              acc_d [NUM_CH];
    acc_t              sum   [NUM_CH];
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;
    logic              load_q, load_d;
    frame_t            avg_q, avg_d;
    logic              overrun_q, overrun_d;
    logic              tick;
    logic              do_acc;
    logic              buf_full;
    sample_t           ch_in [NUM_CH];

    always_comb begin
        ch_in[0] = ch1_data_i;
        ch_in[1] = ch2_data_i;
        ch_in[2] = ch3_data_i;
        ch_in[3] = ch4_data_i;
        ch_in[4] = ch5_data_i;
        ch_in[5] = ch6_data_i;
    end

    assign tick = enable_i && (period_q == PERIOD_LAST);

    always_comb begin
        if (!enable_i || (period_q == PERIOD_LAST)) begin
            period_d = '0;
        end else begin
            period_d = period_q + 16'd1;
        end
    end

    always_comb begin
        state_d   = state_q;
        to_cnt_d  = to_cnt_q;
        tmo_cnt_d = tmo_cnt_q;
        start_d   = 1'b0;
        acc_d     = acc_q;
        fcnt_d    = fcnt_q;
        load_d    = 1'b0;
        avg_d     = avg_q;
        overrun_d = overrun_q;
        do_acc    = 1'b0;

        for (int i = 0; i < NUM_CH; i++) begin
            sum[i] = acc_q[i] + acc_t'(ch_in[i]);
        end

        unique case (state_q)
            StIdle: begin
                if (tick) begin
                    start_d  = 1'b1;
                    to_cnt_d = '0;
                    state_d  = StWaitDone;
                end
            end
            StWaitDone: begin
                // Done takes priority over a timeout expiring in the same cycle.
                if (convst_done_i) begin
                    do_acc  = 1'b1;
                    state_d = StIdle;
                end else if (to_cnt_q == TIMEOUT_LAST) begin
                    if (tmo_cnt_q != 16'hFFFF) begin
                        tmo_cnt_d = tmo_cnt_q + 16'd1;
                    end
                    state_d = StIdle;
                end else begin
                    to_cnt_d = to_cnt_q + 16'd1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (do_acc) begin
            if (fcnt_q == FCNT_LAST) begin
                load_d = 1'b1;
                fcnt_d = '0;
                for (int i = 0; i < NUM_CH; i++) begin
                    // Top DATA_W bits of the full-width sum == arithmetic shift by AVG_LOG2,
                    // i.e. floor division; the sum cannot overflow ACC_W.
                    avg_d[i] = sum[i][ACC_W-1 -: DATA_W];
                    acc_d[i] = '0;
                end
            end else begin
                fcnt_d = fcnt_q + 1'b1;
                for (int i = 0; i < NUM_CH; i++) begin
                    acc_d[i] = sum[i];
                end
            end
        end

        if (load_q && buf_full) begin
            overrun_d = 1'b1;
        end

        if (!enable_i) begin
            state_d   = StIdle;
            start_d   = 1'b0;
            to_cnt_d  = '0;
            fcnt_d    = '0;
            load_d    = 1'b0;
            overrun_d = 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                acc_d[i] = '0;
            end
        end
    end

    always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= StIdle;
            period_q  <= '0;
            to_cnt_q  <= '0;
            tmo_cnt_q <= '0;
            start_q   <= 1'b0;
            fcnt_q    <= '0;
            load_q    <= 1'b0;
            avg_q     <= '0;
            overrun_q <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                acc_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            period_q  <= period_d;
            to_cnt_q  <= to_cnt_d;
            tmo_cnt_q <= tmo_cnt_d;
            start_q   <= start_d;
            fcnt_q    <= fcnt_d;
            load_q    <= load_d;
            avg_q     <= avg_d;
            overrun_q <= overrun_d;
            for (int i = 0; i < NUM_CH; i++) begin
                acc_q[i] <= acc_d[i];
            end
        end
    end

    ad7656_frame_buf u_frame_buf (
        .sys_clk_i (sys_clk_i),
        .rst_n_i   (rst_n_i),
        .load_i    (load_q),
        .frame_i   (avg_q),
        .full_o    (buf_full),
        .m_valid_o (m_valid_o),
        .m_ready_i (m_ready_i),
        .m_data_o  (m_data_o),
        .m_chan_o  (m_chan_o),
        .m_last_o  (m_last_o)
    );

    assign start_flag_o  = start_q;
    assign overrun_o     = overrun_q;
    assign timeout_cnt_o = tmo_cnt_q;

endmodule

// File: doc/ad7656_sample_ctrl.md
# ad7656_sample_ctrl

Sequencing and averaging stage that wraps the AD7656 read driver from both sides. It issues the periodic `start_flag` pulse that triggers each conversion and consumes the resulting six-channel frame on `convst_done`. It averages 2^AVG_LOG2 consecutive frames per channel and streams the six averaged words over a valid/ready interface.

## Interface
- PERIOD_CYC, 1000, sample period in sys_clk_i cycles (100 kHz at 100 MHz); legal range 64..65535
- AVG_LOG2, 2, log2 of frames averaged per output frame; legal range 0..6
- TIMEOUT_CYC, 600, max cycles from start_flag_o to convst_done_i before the conversion is declared lost
- sys_clk_i  in  1  system clock, 100 MHz
- rst_n_i  in  1  reset, asynchronous, active-low
- enable_i  in  1  run enable; low = idle and clear
- start_flag_o  out  1  one-cycle conversion request to the read driver
- convst_done_i  in  1  one-cycle frame-complete pulse from the read driver
- ch1_data_i..ch6_data_i  in  16 each  channel samples, two's complement, valid on convst_done_i
- m_valid_o  out  1  output word valid
- m_ready_i  in  1  downstream accept
- m_data_o  out  16  averaged sample, two's complement
- m_chan_o  out  3  channel index 0..5
- m_last_o  out  1  high on channel 5
- overrun_o  out  1  sticky: averaged frame dropped because the output buffer was full
- timeout_cnt_o  out  16  saturating count of lost conversions

## Operation
- Period counter:
  - Runs 0..PERIOD_CYC-1 while enable_i is high, then wraps.
  - Tick at count PERIOD_CYC-1.
  - Held at 0 while enable_i is low.
- FSM states: IDLE, WAIT_DONE.
  - IDLE, tick: pulse start_flag_o, clear the timeout counter, go to WAIT_DONE.
  - WAIT_DONE, convst_done_i: accumulate, go to IDLE.
  - WAIT_DONE, timeout counter reaches TIMEOUT_CYC-1: increment timeout_cnt_o (saturate at 0xFFFF), go to IDLE, leave the accumulators untouched.
  - A tick arriving while in WAIT_DONE is skipped; no start is issued.
- Accumulate:
  - Six signed accumulators, each 16+AVG_LOG2 bits, each sign-extended and added with its channel input.
  - Frame counter increments.
  - On the frame where the counter reaches 2^AVG_LOG2-1, the sums go to the output (below); accumulators and frame counter then clear.
- Average = arithmetic shift right by AVG_LOG2, truncated toward −∞, 16-bit result. No overflow is possible.
- Output buffer: one 6×16 frame.
  - Loaded from the averages if empty.
  - If full, the frame is dropped and overrun_o is set.
  - Serialised as chan 0..5. A word advances on m_valid_o && m_ready_i. The buffer empties after the chan-5 handshake.
- convst_done_i while in IDLE is ignored.
- convst_done_i on the same cycle the timeout expires: done wins, no timeout count.
- enable_i low:
  - Synchronously clears the period counter, accumulators, frame counter and overrun_o; FSM returns to IDLE.
  - The output buffer keeps draining.
  - timeout_cnt_o is cleared only by reset.

## Timing
- All outputs are registered.
- Reset values: start_flag_o 0, m_valid_o 0, m_data_o 0, m_chan_o 0, m_last_o 0, overrun_o 0, timeout_cnt_o 0.
- First start_flag_o occurs PERIOD_CYC cycles after enable_i rises.
- start_flag_o is exactly one cycle wide.
- Accumulate happens in the convst_done_i cycle.
- The buffer loads the next cycle; m_valid_o rises the cycle after the load, i.e. 2 cycles after the final done.
- m_data_o, m_chan_o and m_last_o hold stable while m_valid_o && !m_ready_i.
- m_valid_o never drops without a handshake, except on reset.
- Back-to-back words are possible at one per cycle with m_ready_i held high.
- The buffer is free the cycle after the chan-5 handshake; a load on that same cycle is accepted (no overrun).

## Structure
- Package ad7656_pkg:
  - NUM_CH=6, DATA_W=16, CHAN_W=3.
  - FSM state enum {IDLE, WAIT_DONE}.
  - Sample type as signed [DATA_W-1:0].
- Sub-module ad7656_frame_buf:
  - 6-word buffer, full flag and serialiser with valid/ready.
  - Load port: load_i, frame_i, full_o.
- Top module holds the period counter, FSM, timeout and accumulators.

## Test plan
- Averaging, AVG_LOG2=2, PERIOD_CYC=100: respond to each start with done after 40 cycles; ch1 = 100, 200, 300, 401 → ch1 output 250 (0x00FA). Six words follow, chan 0..5, m_last_o on chan 5.
- Negative averaging: ch3 = 0xFFFF, 0xFFFF, 0xFFFE, 0xFFFE → 0xFFFE (−1.5 floors to −2).
- Lost conversion: withhold done for 600 cycles → timeout_cnt_o = 1, no accumulation; the next start occurs on the following tick.
- Backpressure and overrun:
  - Hold m_ready_i low for 3 output frames → first frame held stable, overrun_o = 1.
  - Release m_ready_i → the first frame is emitted intact.
- Timeout/done race: done exactly at cycle TIMEOUT_CYC-1 after start → accumulated, timeout_cnt_o unchanged.
- Reset and enable:
  - Drop enable_i mid-frame after 2 of 4 frames; re-enable; feed 4 frames → output is the average of the new 4 frames only.
  - Assert rst_n_i low mid-stream → all outputs are 0 the same cycle.
